fpu_wb_arbiter: RTL and testbench

Writeback arbiter that drives the FPU register file's single write port. It accepts results from two FPU execution sources over valid/ready handshakes and buffers each source in a small FIFO. It arbitrates round-robin and issues at most one registered write per cycle on `wr_en`/`wr_addr`/`wr_data`. It also exports a pending-write mask for the issue stage's hazard checks.

---
 rtl/fpu_wb_pkg.sv | 12 +
 rtl/fpu_wb_arbiter_if.sv | 28 ++
 rtl/fpu_wb_fifo.sv | 66 ++++++
 rtl/fpu_wb_arbiter.sv | 75 +++++++
 tb/tb_fpu_wb_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_wb_pkg.sv
// fpu_wb_pkg: shared widths, grant encoding and one-hot helper for the FPU writeback arbiter
package fpu_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {WB_SRC0, WB_SRC1} wb_src_t;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] r;
    r = '0;
    r[a] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/fpu_wb_arbiter_if.sv
// fpu_wb_arbiter_if: source handshakes, register-file write port and status of the writeback arbiter
interface fpu_wb_arbiter_if
  import fpu_wb_pkg::*;
#(
  parameter int NUM_BITS = 32
);
  logic                  s0_valid;
  logic                  s0_ready;
  logic [REG_ADDR_W-1:0] s0_addr;
  logic [NUM_BITS-1:0]   s0_data;
  logic                  s1_valid;
  logic                  s1_ready;
  logic [REG_ADDR_W-1:0] s1_addr;
  logic [NUM_BITS-1:0]   s1_data;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [NUM_BITS-1:0]   wr_data;
  logic [NUM_REGS-1:0]   pend_mask;
  logic                  idle;
  modport master (
    output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready, wr_en, wr_addr, wr_data, pend_mask, idle
  );
  modport slave (
    input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready, wr_en, wr_addr, wr_data, pend_mask, idle
  );
endinterface

// File: rtl/fpu_wb_fifo.sv
// fpu_wb_fifo: per-source circular buffer of pending register writes with per-entry visibility
module fpu_wb_fifo
  import fpu_wb_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [REG_ADDR_W-1:0]            push_addr,
  input  logic [NUM_BITS-1:0]              push_data,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [REG_ADDR_W-1:0]            head_addr,
  output logic [NUM_BITS-1:0]              head_data,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr,
  output logic [DEPTH-1:0]                 ent_vld
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][NUM_BITS-1:0] data_q, data_d;
  // pop retires the head slot, push fills the tail slot; power-of-two depth makes pointers wrap naturally
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    vld_d = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      vld_d[rp_q] = 1'b0;
      rp_d = rp_q + 1'b1;
    end
    if (push) begin
      vld_d[wp_q] = 1'b1;
      addr_d[wp_q] = push_addr;
      data_d[wp_q] = push_data;
      wp_d = wp_q + 1'b1;
    end
  end
  // occupancy is the per-slot valid vector, so reset discards every buffered entry at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      vld_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      vld_q <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign full = &vld_q;
  assign empty = ~|vld_q;
  assign head_addr = addr_q[rp_q];
  assign head_data = data_q[rp_q];
  assign ent_addr = addr_q;
  assign ent_vld = vld_q;
endmodule

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: round-robin merge of two FPU result streams onto the single register-file write port
module fpu_wb_arbiter
  import fpu_wb_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  fpu_wb_arbiter_if.slave  bus
);
  logic full0, empty0, full1, empty1, push0, push1, pop0, pop1;
  logic [REG_ADDR_W-1:0] ha0, ha1;
  logic [NUM_BITS-1:0] hd0, hd1;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ea0, ea1;
  logic [DEPTH-1:0] ev0, ev1;
  logic rdy_q, rdy_d, wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_BITS-1:0] wr_data_q, wr_data_d;
  wb_src_t last_q, last_d;
  logic [NUM_REGS-1:0] pend;
  assign bus.s0_ready = rdy_q && !full0;
  assign bus.s1_ready = rdy_q && !full1;
  assign push0 = bus.s0_valid && bus.s0_ready;
  assign push1 = bus.s1_valid && bus.s1_ready;
  fpu_wb_fifo #(.NUM_BITS(NUM_BITS), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push0), .push_addr(bus.s0_addr), .push_data(bus.s0_data),
    .pop(pop0), .full(full0), .empty(empty0), .head_addr(ha0), .head_data(hd0),
    .ent_addr(ea0), .ent_vld(ev0)
  );
  fpu_wb_fifo #(.NUM_BITS(NUM_BITS), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .push_addr(bus.s1_addr), .push_data(bus.s1_data),
    .pop(pop1), .full(full1), .empty(empty1), .head_addr(ha1), .head_data(hd1),
    .ent_addr(ea1), .ent_vld(ev1)
  );
  // grant the lone non-empty source, or on a tie the one not granted last; load the winner into the write register
  always_comb begin
    rdy_d = 1'b1;
    pop0 = !empty0 && (empty1 || last_q == WB_SRC1);
    pop1 = !empty1 && !pop0;
    last_d = pop0 ? WB_SRC0 : (pop1 ? WB_SRC1 : last_q);
    wr_en_d = pop0 || pop1;
    wr_addr_d = pop0 ? ha0 : (pop1 ? ha1 : wr_addr_q);
    wr_data_d = pop0 ? hd0 : (pop1 ? hd1 : wr_data_q);
  end
  // registered write port; ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q <= WB_SRC1;
    end else begin
      rdy_q <= rdy_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q <= last_d;
    end
  end
  // every buffered destination plus the one being presented is a pending write
  always_comb begin
    pend = wr_en_q ? onehot(wr_addr_q) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend = ev0[i] ? (pend | onehot(ea0[i])) : pend;
      pend = ev1[i] ? (pend | onehot(ea1[i])) : pend;
    end
  end
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.pend_mask = pend;
  assign bus.idle = empty0 && empty1 && !wr_en_q;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// tb_fpu_wb_arbiter: directed scoreboard bench for the FPU writeback arbiter
module tb_fpu_wb_arbiter;
  import fpu_wb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int wlog[$];
  int wcyc[$];
  logic [36:0] cur_e, exp_e;
  int src;
  bit nrdy0, nrdy1;
  int wsz;

  fpu_wb_arbiter_if #(.NUM_BITS(32)) bus ();
  fpu_wb_arbiter #(.NUM_BITS(32), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: writes must match the oldest outstanding push of one source; handshakes record new expectations
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      cur_e = {bus.wr_addr, bus.wr_data};
      if (q0.size() > 0 && q0[0] === cur_e) begin
        exp_e = q0.pop_front();
        src = 0;
      end else if (q1.size() > 0 && q1[0] === cur_e) begin
        exp_e = q1.pop_front();
        src = 1;
      end else begin
        exp_e = q0.size() > 0 ? q0[0] : (q1.size() > 0 ? q1[0] : ~cur_e);
        src = 2;
      end
      wlog.push_back(src);
      wcyc.push_back(cyc);
      chk("wr_order", 64'(cur_e), 64'(exp_e));
    end
    if (bus.s0_valid && bus.s0_ready) q0.push_back({bus.s0_addr, bus.s0_data});
    if (bus.s1_valid && bus.s1_ready) q1.push_back({bus.s1_addr, bus.s1_data});
  end

  task automatic stream(input int n0, input int a0, input int n1, input int a1);
    int i0 = 0;
    int i1 = 0;
    int guard = 0;
    bit acc0, acc1;
    nrdy0 = 0;
    nrdy1 = 0;
    while ((i0 < n0 || i1 < n1) && guard < 200) begin
      bus.s0_valid = (i0 < n0);
      bus.s0_addr = 5'(a0 + i0);
      bus.s0_data = 32'hA000_0000 | 32'(i0);
      bus.s1_valid = (i1 < n1);
      bus.s1_addr = 5'(a1 + i1);
      bus.s1_data = 32'hB000_0000 | 32'(i1);
      acc0 = bus.s0_valid && bus.s0_ready;
      acc1 = bus.s1_valid && bus.s1_ready;
      if (bus.s0_valid && !bus.s0_ready) nrdy0 = 1;
      if (bus.s1_valid && !bus.s1_ready) nrdy1 = 1;
      step();
      guard++;
      if (acc0) i0++;
      if (acc1) i1++;
    end
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    chk("stream_done", 64'(guard < 200), 64'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!bus.idle && g < 50) begin
      step();
      g++;
    end
    chk("idle_reached", 64'(bus.idle), 64'd1);
    chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    bus.s0_valid = 1'b0;
    bus.s0_addr = '0;
    bus.s0_data = '0;
    bus.s1_valid = 1'b0;
    bus.s1_addr = '0;
    bus.s1_data = '0;
    step();
    step();
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_pend", 64'(bus.pend_mask), 64'd0);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_rdy0", 64'(bus.s0_ready), 64'd0);
    chk("rst_rdy1", 64'(bus.s1_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_rdy0_pre", 64'(bus.s0_ready), 64'd0);
    step();
    chk("rel_rdy0", 64'(bus.s0_ready), 64'd1);
    chk("rel_rdy1", 64'(bus.s1_ready), 64'd1);

    // both sources streaming: strict alternation starting with s0, each ready dips
    wlog.delete();
    stream(6, 1, 6, 17);
    wait_idle();
    chk("t2_nwr", 64'(wlog.size()), 64'd12);
    for (int k = 0; k < 8; k++) chk("t2_alt", 64'(wlog[k]), 64'(k % 2));
    chk("t2_nrdy0", 64'(nrdy0), 64'd1);
    chk("t2_nrdy1", 64'(nrdy1), 64'd1);

    // single push latency and pend_mask window
    bus.s0_valid = 1'b1;
    bus.s0_addr = 5'd3;
    bus.s0_data = 32'h3F80_0000;
    step();
    bus.s0_valid = 1'b0;
    chk("t1_n1_wr_en", 64'(bus.wr_en), 64'd0);
    chk("t1_n1_pend", 64'(bus.pend_mask), 64'h8);
    step();
    chk("t1_n2_wr_en", 64'(bus.wr_en), 64'd1);
    chk("t1_n2_addr", 64'(bus.wr_addr), 64'd3);
    chk("t1_n2_data", 64'(bus.wr_data), 64'h3F80_0000);
    chk("t1_n2_pend", 64'(bus.pend_mask), 64'h8);
    step();
    chk("t1_n3_wr_en", 64'(bus.wr_en), 64'd0);
    chk("t1_n3_pend", 64'(bus.pend_mask), 64'd0);
    chk("t1_n3_addr_hold", 64'(bus.wr_addr), 64'd3);

    // register 0 is an ordinary destination
    bus.s1_valid = 1'b1;
    bus.s1_addr = 5'd0;
    bus.s1_data = 32'h0000_ABCD;
    step();
    bus.s1_valid = 1'b0;
    chk("t6_n1_pend", 64'(bus.pend_mask), 64'h1);
    chk("t6_n1_idle", 64'(bus.idle), 64'd0);
    step();
    chk("t6_n2_wr_en", 64'(bus.wr_en), 64'd1);
    chk("t6_n2_addr", 64'(bus.wr_addr), 64'd0);
    chk("t6_n2_data", 64'(bus.wr_data), 64'h0000_ABCD);
    chk("t6_n2_pend", 64'(bus.pend_mask), 64'h1);
    step();
    chk("t6_n3_idle", 64'(bus.idle), 64'd1);
    chk("t6_n3_pend", 64'(bus.pend_mask), 64'd0);

    // s0 burst of four against two s1 entries: six back-to-back writes
    wlog.delete();
    wcyc.delete();
    stream(4, 4, 2, 24);
    wait_idle();
    chk("t3_nwr", 64'(wlog.size()), 64'd6);
    if (wlog.size() == 6) begin
      chk("t3_span", 64'(wcyc[5] - wcyc[0]), 64'd5);
      chk("t3_src0", 64'(wlog[0]), 64'd0);
      chk("t3_src1", 64'(wlog[1]), 64'd1);
      chk("t3_src2", 64'(wlog[2]), 64'd0);
      chk("t3_src3", 64'(wlog[3]), 64'd1);
      chk("t3_src4", 64'(wlog[4]), 64'd0);
      chk("t3_src5", 64'(wlog[5]), 64'd0);
    end

    // s1 fills under contention, entries wait for a pop, pointers wrap over ten pushes
    wlog.delete();
    stream(10, 0, 10, 20);
    wait_idle();
    chk("t4_nwr", 64'(wlog.size()), 64'd20);
    chk("t4_nrdy1", 64'(nrdy1), 64'd1);

    // reset with entries buffered and a write presented
    bus.s0_valid = 1'b1;
    bus.s0_addr = 5'd8;
    bus.s0_data = 32'hC000_0008;
    bus.s1_valid = 1'b1;
    bus.s1_addr = 5'd28;
    bus.s1_data = 32'hD000_001C;
    step();
    bus.s0_addr = 5'd9;
    bus.s0_data = 32'hC000_0009;
    bus.s1_addr = 5'd29;
    bus.s1_data = 32'hD000_001D;
    step();
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    chk("t5_pre_wr_en", 64'(bus.wr_en), 64'd1);
    rst = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    chk("t5_wr_en", 64'(bus.wr_en), 64'd0);
    chk("t5_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("t5_wr_data", 64'(bus.wr_data), 64'd0);
    chk("t5_pend", 64'(bus.pend_mask), 64'd0);
    chk("t5_idle", 64'(bus.idle), 64'd1);
    chk("t5_rdy0", 64'(bus.s0_ready), 64'd0);
    chk("t5_rdy1", 64'(bus.s1_ready), 64'd0);
    step();
    step();
    rst = 1'b1;
    wsz = wlog.size();
    for (int k = 0; k < 10; k++) step();
    chk("t5_no_stale", 64'(wlog.size()), 64'(wsz));
    chk("t5_idle_after", 64'(bus.idle), 64'd1);
    chk("t5_rdy_after", 64'(bus.s0_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
